// File: rtl/byte_bus_sram_if.sv
// Strobe/address/ack bundle between the PIO side and the byte SRAM.
// The bidirectional data byte stays a plain inout on the target.
interface byte_bus_sram_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_cs_n;
    logic              bus_we_n;
    logic              bus_oe_n;
    logic              bus_ack;

    modport master (
        output bus_addr, bus_cs_n, bus_we_n, bus_oe_n,
        input  bus_ack
    );

    modport slave (
        input  bus_addr, bus_cs_n, bus_we_n, bus_oe_n,
        output bus_ack
    );
endinterface

// File: rtl/byte_bus_sram.sv
// Byte-wide SRAM target behind a bit-banged four-phase strobe/ack bus.
// Read data and drive enable are registered; the bus is released on reset.
module byte_bus_sram #(
    parameter int ADDR_W   = 8,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [7:0]       bus_data,
    byte_bus_sram_if.slave   bus,
    output logic             busy,
    output logic             err_collision,
    output logic [CNT_W-1:0] wr_count
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_DRIVE,
        RECOVER
    } state_t;

    localparam int CW = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD =
        CW'((READ_LAT > 2) ? READ_LAT - 2 : 0);

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    mem [2**ADDR_W];
    logic [7:0]    rd_q;
    logic          drv_en, ack_q;
    logic          wr_go, rd_go, err_set, drv_d, ack_d;
    logic          sel, we, oe;

    assign sel = !bus.bus_cs_n;
    assign we  = !bus.bus_we_n;
    assign oe  = !bus.bus_oe_n;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        wr_go   = 1'b0;
        rd_go   = 1'b0;
        err_set = 1'b0;
        drv_d   = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel && we && oe) begin
                    err_set = 1'b1;
                end else if (sel && we) begin
                    wr_go   = 1'b1;
                    state_d = WRITE;
                end else if (sel && oe) begin
                    rd_go   = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (READ_LAT == 1) ? READ_DRIVE : READ_WAIT;
                end
            end
            WRITE: begin
                if (!(sel && we)) state_d = RECOVER;
            end
            READ_WAIT: begin
                if (!(sel && oe))   state_d = RECOVER;
                else if (cnt == '0) state_d = READ_DRIVE;
                else                cnt_d   = cnt - CW'(1);
            end
            READ_DRIVE: begin
                // A write strobe on top of an active read is a bus fight
                if (sel && oe && we) begin
                    err_set = 1'b1;
                    state_d = RECOVER;
                end else if (!(sel && oe)) begin
                    state_d = RECOVER;
                end else begin
                    drv_d = 1'b1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d = (state_d == WRITE) || drv_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            drv_en        <= 1'b0;
            ack_q         <= 1'b0;
            err_collision <= 1'b0;
            wr_count      <= '0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            drv_en <= drv_d;
            ack_q  <= ack_d;
            if (err_set) err_collision <= 1'b1;
            if (wr_go)   wr_count <= wr_count + CNT_W'(1);
        end
    end

    // Array and read register carry no reset
    always_ff @(posedge clk) begin
        if (wr_go) mem[bus.bus_addr] <= bus_data;
        if (rd_go) rd_q <= mem[bus.bus_addr];
    end

    assign bus_data    = drv_en ? rd_q : 8'hzz;
    assign bus.bus_ack = ack_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_byte_bus_sram.sv
// Directed bench for byte_bus_sram: a READ_LAT=2 and a READ_LAT=1 target
// share one stimulus; released bus lines float high through tri1 nets.
module tb_byte_bus_sram;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       cs_n = 1'b1;
    logic       we_n = 1'b1;
    logic       oe_n = 1'b1;
    logic       wdrv = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wdata = 8'h00;

    tri1 [7:0] bus2;
    tri1 [7:0] bus1;

    logic        busy2, busy1, err2, err1;
    logic [15:0] cnt2, cnt1;

    byte_bus_sram_if #(.ADDR_W(8)) if2 ();
    byte_bus_sram_if #(.ADDR_W(8)) if1 ();

    assign if2.bus_addr = addr;
    assign if2.bus_cs_n = cs_n;
    assign if2.bus_we_n = we_n;
    assign if2.bus_oe_n = oe_n;
    assign if1.bus_addr = addr;
    assign if1.bus_cs_n = cs_n;
    assign if1.bus_we_n = we_n;
    assign if1.bus_oe_n = oe_n;

    assign bus2 = wdrv ? wdata : 8'hzz;
    assign bus1 = wdrv ? wdata : 8'hzz;

    byte_bus_sram #(.ADDR_W(8), .READ_LAT(2), .CNT_W(16)) dut2 (
        .clk           (clk),
        .reset         (reset),
        .bus_data      (bus2),
        .bus           (if2.slave),
        .busy          (busy2),
        .err_collision (err2),
        .wr_count      (cnt2)
    );

    byte_bus_sram #(.ADDR_W(8), .READ_LAT(1), .CNT_W(16)) dut1 (
        .clk           (clk),
        .reset         (reset),
        .bus_data      (bus1),
        .bus           (if1.slave),
        .busy          (busy1),
        .err_collision (err1),
        .wr_count      (cnt1)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  model [256];
    logic [7:0]  sb [$];
    logic [15:0] exp_cnt = 16'd0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        addr  = a;
        wdata = d;
        wdrv  = 1'b1;
        cs_n  = 1'b0;
        we_n  = 1'b0;
        tick();
        model[a] = d;
        exp_cnt  = exp_cnt + 16'd1;
        chk("wr_ack", 32'(if2.bus_ack), 32'd1);
        chk("wr_busy", 32'(busy2), 32'd1);
        chk("wr_count", 32'(cnt2), 32'(exp_cnt));
        cs_n = 1'b1;
        we_n = 1'b1;
        wdrv = 1'b0;
        tick();
        chk("wr_rel_ack", 32'(if2.bus_ack), 32'd0);
        chk("wr_recover", 32'(busy2), 32'd1);
        tick();
        chk("wr_idle", 32'(busy2), 32'd0);
    endtask

    task automatic do_read(input logic [7:0] a);
        logic [7:0] exp;
        addr = a;
        cs_n = 1'b0;
        oe_n = 1'b0;
        sb.push_back(model[a]);
        tick();
        chk("rd_z_e0", 32'(bus2), 32'hFF);
        chk("rd_ack_e0", 32'(if2.bus_ack), 32'd0);
        tick();
        chk("rd_z_e1", 32'(bus2), 32'hFF);
        chk("rd_ack_e1", 32'(if2.bus_ack), 32'd0);
        tick();
        exp = sb.pop_front();
        chk("rd_ack", 32'(if2.bus_ack), 32'd1);
        chk("rd_data", 32'(bus2), 32'(exp));
        cs_n = 1'b1;
        oe_n = 1'b1;
        tick();
        chk("rd_rel_bus", 32'(bus2), 32'hFF);
        chk("rd_rel_ack", 32'(if2.bus_ack), 32'd0);
        tick();
        chk("rd_idle", 32'(busy2), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rst_ack", 32'(if2.bus_ack), 32'd0);
        chk("rst_busy", 32'(busy2), 32'd0);
        chk("rst_err", 32'(err2), 32'd0);
        chk("rst_cnt", 32'(cnt2), 32'd0);
        chk("rst_bus", 32'(bus2), 32'hFF);

        // Basic write and read-back
        do_write(8'h10, 8'hA5);
        do_read(8'h10);

        // Simultaneous write and read strobe
        addr  = 8'h10;
        wdata = 8'h3C;
        wdrv  = 1'b1;
        cs_n  = 1'b0;
        we_n  = 1'b0;
        oe_n  = 1'b0;
        tick();
        chk("col_err", 32'(err2), 32'd1);
        chk("col_ack", 32'(if2.bus_ack), 32'd0);
        chk("col_busy", 32'(busy2), 32'd0);
        chk("col_cnt", 32'(cnt2), 32'(exp_cnt));
        cs_n = 1'b1;
        we_n = 1'b1;
        oe_n = 1'b1;
        wdrv = 1'b0;
        tick();
        do_read(8'h10);
        chk("col_sticky", 32'(err2), 32'd1);

        // Reset while driving read data
        addr = 8'h10;
        cs_n = 1'b0;
        oe_n = 1'b0;
        sb.push_back(model[8'h10]);
        tick();
        tick();
        tick();
        exp = sb.pop_front();
        chk("pre_rst_data", 32'(bus2), 32'(exp));
        reset = 1'b1;
        #2;
        chk("async_bus", 32'(bus2), 32'hFF);
        chk("async_ack", 32'(if2.bus_ack), 32'd0);
        chk("async_busy", 32'(busy2), 32'd0);
        chk("async_err", 32'(err2), 32'd0);
        chk("async_cnt", 32'(cnt2), 32'd0);
        cs_n = 1'b1;
        oe_n = 1'b1;
        tick();
        reset   = 1'b0;
        exp_cnt = 16'd0;
        tick();
        do_read(8'h10);

        // Full address sweep
        for (int i = 0; i < 256; i++)
            do_write(8'(i), 8'(i) ^ 8'h5A);
        chk("sweep_cnt", 32'(cnt2), 32'd256);
        for (int i = 0; i < 256; i++)
            do_read(8'(i));

        // Long write strobe with wandering address and data
        addr  = 8'h20;
        wdata = 8'h77;
        wdrv  = 1'b1;
        cs_n  = 1'b0;
        we_n  = 1'b0;
        tick();
        model[8'h20] = 8'h77;
        exp_cnt = exp_cnt + 16'd1;
        for (int i = 1; i < 10; i++) begin
            addr  = 8'h20 + 8'(i);
            wdata = 8'h80 + 8'(i);
            tick();
            chk("hold_ack", 32'(if2.bus_ack), 32'd1);
            chk("hold_cnt", 32'(cnt2), 32'(exp_cnt));
        end
        cs_n = 1'b1;
        we_n = 1'b1;
        wdrv = 1'b0;
        tick();
        tick();
        chk("hold_cnt1", 32'(cnt1), 32'(exp_cnt));
        do_read(8'h20);
        do_read(8'h21);
        do_read(8'h29);

        // Single-cycle latency target
        addr = 8'h20;
        cs_n = 1'b0;
        oe_n = 1'b0;
        sb.push_back(model[8'h20]);
        tick();
        tick();
        exp = sb.pop_front();
        chk("lat1_ack", 32'(if1.bus_ack), 32'd1);
        chk("lat1_data", 32'(bus1), 32'(exp));
        cs_n = 1'b1;
        oe_n = 1'b1;
        tick();
        chk("lat1_rel_bus", 32'(bus1), 32'hFF);
        chk("lat1_rel_ack", 32'(if1.bus_ack), 32'd0);
        tick();
        tick();

        // Write strobe while driving read data
        addr = 8'h30;
        cs_n = 1'b0;
        oe_n = 1'b0;
        sb.push_back(model[8'h30]);
        tick();
        tick();
        tick();
        exp = sb.pop_front();
        chk("fight_pre", 32'(bus2), 32'(exp));
        we_n = 1'b0;
        tick();
        chk("fight_bus", 32'(bus2), 32'hFF);
        chk("fight_ack", 32'(if2.bus_ack), 32'd0);
        chk("fight_err", 32'(err2), 32'd1);
        chk("fight_cnt", 32'(cnt2), 32'(exp_cnt));
        cs_n = 1'b1;
        oe_n = 1'b1;
        we_n = 1'b1;
        tick();
        tick();
        do_read(8'h30);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
